// File: rtl/reveal_ctrl.sv
// Command sequencer for the 8x8 minesweeper board: turns player commands into flag/reveal pulses,
// flood-fills zero regions through a 64-entry FIFO. Define REVEAL_CTRL_CHORD_EN to build chord reveals.
module reveal_ctrl #(
    parameter int NUM_MINES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_flag,
    input  logic        cmd_reveal,
    input  logic [5:0]  cmd_index,
    input  logic [63:0] mines,
    input  logic [63:0] flagged,
    input  logic [63:0] revealed,
    input  logic [5:0]  reveal_count,
    output logic [5:0]  ts_index,
    output logic        ts_flag,
    output logic        ts_reveal,
    output logic        game_lost,
    output logic        game_won
);

    localparam logic [5:0] WIN_CNT = 6'(64 - NUM_MINES);

    typedef enum logic [2:0] {
        IDLE, FLAG, POP, EXPAND, CHECK, LOST, WON
`ifdef REVEAL_CTRL_CHORD_EN
        , CHORD
`endif
    } state_t;

    state_t      state;
    logic [5:0]  cur;
    logic [2:0]  dir;
    logic [63:0] queued;
    logic [5:0]  mem [64];
    logic [5:0]  wr_ptr;
    logic [5:0]  rd_ptr;
    logic [6:0]  cnt;

    logic        scanning;
    logic [6:0]  scan;
    logic        enq;
    logic        deq;
    logic [3:0]  adj_cur;
    logic        fifo_empty;
    logic        last_scan;
    logic        pop_more;
    logic [5:0]  head;

    // Returns {on_grid, index} of neighbour d (N,NE,E,SE,S,SW,W,NW) of tile i; no wrap.
    function automatic logic [6:0] nbr(input logic [5:0] i, input logic [2:0] d);
        logic signed [4:0] dr;
        logic signed [4:0] dc;
        logic signed [4:0] r;
        logic signed [4:0] c;
        case (d)
            3'd0:    begin dr = -5'sd1; dc =  5'sd0; end
            3'd1:    begin dr = -5'sd1; dc =  5'sd1; end
            3'd2:    begin dr =  5'sd0; dc =  5'sd1; end
            3'd3:    begin dr =  5'sd1; dc =  5'sd1; end
            3'd4:    begin dr =  5'sd1; dc =  5'sd0; end
            3'd5:    begin dr =  5'sd1; dc = -5'sd1; end
            3'd6:    begin dr =  5'sd0; dc = -5'sd1; end
            default: begin dr = -5'sd1; dc = -5'sd1; end
        endcase
        r = $signed({2'b00, i[5:3]}) + dr;
        c = $signed({2'b00, i[2:0]}) + dc;
        return {(r >= 5'sd0) && (r <= 5'sd7) && (c >= 5'sd0) && (c <= 5'sd7), r[2:0], c[2:0]};
    endfunction

    function automatic logic [3:0] nbr_count(input logic [5:0] i, input logic [63:0] map);
        logic [6:0] n;
        logic [3:0] total;
        total = 4'd0;
        for (int d = 0; d < 8; d++) begin
            n = nbr(i, 3'(d));
            if (n[6] && map[n[5:0]]) total = total + 4'd1;
        end
        return total;
    endfunction

`ifdef REVEAL_CTRL_CHORD_EN
    logic chord_ok;
    assign chord_ok = revealed[cmd_index] && (nbr_count(cmd_index, mines) != 4'd0) &&
                      (nbr_count(cmd_index, flagged) == nbr_count(cmd_index, mines));
`endif

    always_comb begin
        scanning = (state == EXPAND);
`ifdef REVEAL_CTRL_CHORD_EN
        scanning = scanning || (state == CHORD);
`endif
        scan       = nbr(cur, dir);
        enq        = scanning && scan[6] && !revealed[scan[5:0]] && !flagged[scan[5:0]] &&
                     !queued[scan[5:0]];
        adj_cur    = nbr_count(cur, mines);
        fifo_empty = (cnt == 7'd0);
        last_scan  = scanning && (dir == 3'd7);
        pop_more   = (state == POP) && !mines[cur] && (adj_cur != 4'd0) && !fifo_empty;
        deq        = pop_more || (last_scan && (enq || !fifo_empty));
        // An empty FIFO at the last scan step hands the just-found neighbour straight through.
        head       = fifo_empty ? scan[5:0] : mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= scan[5:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            ts_index  <= 6'd0;
            ts_flag   <= 1'b0;
            ts_reveal <= 1'b0;
            game_lost <= 1'b0;
            game_won  <= 1'b0;
            cur       <= 6'd0;
            dir       <= 3'd0;
            queued    <= 64'd0;
            wr_ptr    <= 6'd0;
            rd_ptr    <= 6'd0;
            cnt       <= 7'd0;
        end else begin
            ts_flag   <= 1'b0;
            ts_reveal <= 1'b0;
            cmd_ready <= 1'b0;
            wr_ptr    <= wr_ptr + {5'd0, enq};
            rd_ptr    <= rd_ptr + {5'd0, deq};
            cnt       <= cnt + {6'd0, enq} - {6'd0, deq};
            if (enq) queued[scan[5:0]] <= 1'b1;

            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_reveal) begin
                            // The first tile skips the FIFO: it would be popped straight away.
                            if (!flagged[cmd_index] && !revealed[cmd_index]) begin
                                cur               <= cmd_index;
                                ts_index          <= cmd_index;
                                ts_reveal         <= 1'b1;
                                queued[cmd_index] <= 1'b1;
                                cmd_ready         <= 1'b0;
                                state             <= POP;
                            end
`ifdef REVEAL_CTRL_CHORD_EN
                            else if (chord_ok) begin
                                cur       <= cmd_index;
                                dir       <= 3'd0;
                                cmd_ready <= 1'b0;
                                state     <= CHORD;
                            end
`endif
                        end else if (cmd_flag && !revealed[cmd_index]) begin
                            ts_index  <= cmd_index;
                            ts_flag   <= 1'b1;
                            cmd_ready <= 1'b0;
                            state     <= FLAG;
                        end
                    end
                end
                FLAG: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                POP: begin
                    if (mines[cur]) begin
                        game_lost <= 1'b1;
                        queued    <= 64'd0;
                        wr_ptr    <= 6'd0;
                        rd_ptr    <= 6'd0;
                        cnt       <= 7'd0;
                        state     <= LOST;
                    end else if (adj_cur == 4'd0) begin
                        dir   <= 3'd0;
                        state <= EXPAND;
                    end else if (deq) begin
                        cur       <= head;
                        ts_index  <= head;
                        ts_reveal <= 1'b1;
                    end else begin
                        state <= CHECK;
                    end
                end
                EXPAND
`ifdef REVEAL_CTRL_CHORD_EN
                , CHORD
`endif
                : begin
                    dir <= dir + 3'd1;
                    if (last_scan) begin
                        if (deq) begin
                            cur       <= head;
                            ts_index  <= head;
                            ts_reveal <= 1'b1;
                            state     <= POP;
                        end else begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    // reveal_count already reflects the final reveal pulse here.
                    queued <= 64'd0;
                    if (reveal_count == WIN_CNT) begin
                        game_won <= 1'b1;
                        state    <= WON;
                    end else begin
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                LOST, WON: state <= state;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reveal_ctrl.sv
// Directed bench for reveal_ctrl with a tile_state stand-in and a set-based flood model.
module tb_reveal_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_flag = 1'b0;
    logic        cmd_reveal = 1'b0;
    logic [5:0]  cmd_index = 6'd0;
    logic [63:0] mines = 64'd0;
    logic [63:0] flagged_m;
    logic [63:0] revealed_m;
    logic [5:0]  reveal_count;
    logic        cmd_ready;
    logic [5:0]  ts_index;
    logic        ts_flag;
    logic        ts_reveal;
    logic        game_lost;
    logic        game_won;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;

    logic [63:0] exp_set = 64'd0;
    logic [63:0] seen = 64'd0;
    logic        exp_flag_en = 1'b0;
    logic [5:0]  exp_flag_idx = 6'd0;
    int nrev = 0, nflag = 0, first_cyc = -1, epoch = 0, last_epoch = 0;
    int acc_cyc = 0, done_cyc = 0;

    reveal_ctrl #(.NUM_MINES(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_flag(cmd_flag), .cmd_reveal(cmd_reveal), .cmd_index(cmd_index),
        .mines(mines), .flagged(flagged_m), .revealed(revealed_m), .reveal_count(reveal_count),
        .ts_index(ts_index), .ts_flag(ts_flag), .ts_reveal(ts_reveal),
        .game_lost(game_lost), .game_won(game_won)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // tile_state stand-in
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            flagged_m  <= 64'd0;
            revealed_m <= 64'd0;
        end else begin
            if (ts_reveal) begin
                revealed_m[ts_index] <= 1'b1;
                flagged_m[ts_index]  <= 1'b0;
            end
            if (ts_flag && !revealed_m[ts_index]) flagged_m[ts_index] <= !flagged_m[ts_index];
        end
    end
    always_comb reveal_count = 6'($countones(revealed_m));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int m_adj(input int t, input logic [63:0] mm);
        int n = 0;
        for (int r = t / 8 - 1; r <= t / 8 + 1; r++)
            for (int c = t % 8 - 1; c <= t % 8 + 1; c++)
                if (r >= 0 && r < 8 && c >= 0 && c < 8 && (r * 8 + c) != t && mm[r * 8 + c]) n++;
        return n;
    endfunction

    // Grow a seed set: every safe zero-count tile pulls in its hidden, unflagged neighbours.
    function automatic logic [63:0] m_expand(input logic [63:0] s, input logic [63:0] mm,
                                             input logic [63:0] fl, input logic [63:0] rv);
        logic [63:0] set;
        bit changed;
        set = s;
        do begin
            changed = 0;
            for (int t = 0; t < 64; t++) begin
                if (set[t] && !mm[t] && m_adj(t, mm) == 0) begin
                    for (int r = t / 8 - 1; r <= t / 8 + 1; r++)
                        for (int c = t % 8 - 1; c <= t % 8 + 1; c++)
                            if (r >= 0 && r < 8 && c >= 0 && c < 8 && !rv[r * 8 + c] &&
                                !fl[r * 8 + c] && !set[r * 8 + c]) begin
                                set[r * 8 + c] = 1'b1;
                                changed = 1;
                            end
                end
            end
        end while (changed);
        return set;
    endfunction

    function automatic logic [63:0] m_flood(input int s, input logic [63:0] mm);
        logic [63:0] seed;
        seed = 64'd0;
        seed[s] = 1'b1;
        return m_expand(seed, mm, 64'd0, 64'd0);
    endfunction

    // Per-cycle compare against the expected pulse set of the current command.
    always @(negedge clk) begin
        if (rst) begin
            if (epoch != last_epoch) begin
                seen = 64'd0; nrev = 0; nflag = 0; first_cyc = -1; last_epoch = epoch;
            end
            chk("pulse_excl", 64'(ts_flag & ts_reveal), 64'd0);
            chk("ready_after_end", 64'(cmd_ready & (game_lost | game_won)), 64'd0);
            if (ts_reveal) begin
                chk("reveal_idx_expected", 64'(exp_set[ts_index] && !seen[ts_index]), 64'd1);
                seen[ts_index] = 1'b1;
                nrev++;
                if (first_cyc < 0) first_cyc = cyc;
            end
            if (ts_flag) begin
                chk("flag_idx", {57'd0, exp_flag_en, ts_index}, {57'd1, exp_flag_idx});
                nflag++;
                if (first_cyc < 0) first_cyc = cyc;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic issue(input logic f, input logic r, input logic [5:0] idx);
        int n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("ready_before_cmd", 64'(cmd_ready), 64'd1);
        epoch++;
        acc_cyc = cyc;
        cmd_valid = 1'b1; cmd_flag = f; cmd_reveal = r; cmd_index = idx;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_flag = 1'b0; cmd_reveal = 1'b0;
    endtask

    task automatic run(input logic f, input logic r, input logic [5:0] idx, input logic [63:0] es,
                       input int enf, input logic el, input logic ew);
        int n = 0;
        exp_set = es;
        exp_flag_en = (enf > 0);
        exp_flag_idx = idx;
        issue(f, r, idx);
        while (!(cmd_ready || game_lost || game_won) && n < 2000) begin @(negedge clk); n++; end
        chk("cmd_done_in_time", 64'(n < 2000), 64'd1);
        done_cyc = cyc;
        chk("reveal_set", seen, es);
        chk("flag_pulses", 64'(nflag), 64'(enf));
        chk("game_lost", 64'(game_lost), 64'(el));
        chk("game_won", 64'(game_won), 64'(ew));
    endtask

    initial begin
        logic [63:0] e;
        int n;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(cmd_ready), 64'd0);
        chk("rst_outs", {56'd0, ts_index, ts_flag, ts_reveal}, 64'd0);
        chk("rst_game", {62'd0, game_lost, game_won}, 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_rst", 64'(cmd_ready), 64'd1);

        // Flag toggles and reveal of a flagged tile
        mines = 64'd1;
        run(1'b1, 1'b0, 6'd9, 64'd0, 1, 1'b0, 1'b0);
        chk("flag_latency", 64'(first_cyc - acc_cyc), 64'd1);
        run(1'b1, 1'b0, 6'd9, 64'd0, 1, 1'b0, 1'b0);
        run(1'b1, 1'b0, 6'd9, 64'd0, 1, 1'b0, 1'b0);
        chk("tile9_flagged", 64'(flagged_m[9]), 64'd1);
        run(1'b0, 1'b1, 6'd9, 64'd0, 0, 1'b0, 1'b0);
        chk("flagged_reveal_noop", 64'(nrev), 64'd0);

        // Single numbered tile
        do_reset();
        mines = 64'h0000_0000_0000_0103;
        chk("model_adj9", 64'(m_adj(9, mines)), 64'd3);
        e = m_flood(9, mines);
        chk("model_set9", e, 64'h0000_0000_0000_0200);
        run(1'b0, 1'b1, 6'd9, e, 0, 1'b0, 1'b0);
        chk("reveal_latency", 64'(first_cyc - acc_cyc), 64'd1);
        chk("idle_latency", 64'(done_cyc - acc_cyc), 64'd3);

        // Whole-board flood to a win
        do_reset();
        mines = 64'd1;
        e = m_flood(63, mines);
        chk("model_flood_size", 64'($countones(e)), 64'd63);
        chk("model_flood_bit0", 64'(e[0]), 64'd0);
        run(1'b0, 1'b1, 6'd63, e, 0, 1'b0, 1'b1);
        chk("flood_pulses", 64'(nrev), 64'd63);
        epoch++;
        exp_set = 64'd0; exp_flag_en = 1'b0;
        cmd_valid = 1'b1; cmd_flag = 1'b1; cmd_index = 6'd5;
        repeat (6) @(negedge clk);
        cmd_valid = 1'b0; cmd_flag = 1'b0;
        chk("won_ready", 64'(cmd_ready), 64'd0);
        chk("won_held", 64'(game_won), 64'd1);
        chk("won_no_pulse", 64'(nrev + nflag), 64'd0);

        // Mine hit
        do_reset();
        mines = 64'd1 << 27;
        run(1'b0, 1'b1, 6'd27, 64'd1 << 27, 0, 1'b1, 1'b0);
        chk("mine_pulses", 64'(nrev), 64'd1);
        epoch++;
        exp_set = 64'd0;
        cmd_valid = 1'b1; cmd_reveal = 1'b1; cmd_index = 6'd10;
        repeat (6) @(negedge clk);
        cmd_valid = 1'b0; cmd_reveal = 1'b0;
        chk("lost_ready", 64'(cmd_ready), 64'd0);
        chk("lost_no_pulse", 64'(nrev + nflag), 64'd0);
        chk("lost_held", 64'(game_lost), 64'd1);

        // Reset in the middle of a flood
        do_reset();
        mines = 64'd1;
        exp_set = m_flood(63, mines);
        exp_flag_en = 1'b0;
        issue(1'b0, 1'b1, 6'd63);
        n = 0;
        while (nrev < 10 && n < 500) begin @(negedge clk); n++; end
        chk("flood_progress", 64'(nrev), 64'd10);
        #1 rst = 1'b0;
        #1;
        chk("midrst_outs", {56'd0, ts_index, ts_flag, ts_reveal}, 64'd0);
        chk("midrst_state", {61'd0, cmd_ready, game_lost, game_won}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_ready", 64'(cmd_ready), 64'd1);
        run(1'b0, 1'b1, 6'd9, 64'd1 << 9, 0, 1'b0, 1'b0);
        chk("midrst_single", 64'(nrev), 64'd1);

`ifdef REVEAL_CTRL_CHORD_EN
        // Chord around tile 9 with the mine flagged
        do_reset();
        mines = 64'd1;
        run(1'b0, 1'b1, 6'd9, 64'd1 << 9, 0, 1'b0, 1'b0);
        run(1'b1, 1'b0, 6'd0, 64'd0, 1, 1'b0, 1'b0);
        e = m_expand(64'h0000_0000_0007_0506, mines, flagged_m, revealed_m);
        chk("model_chord", e, ~64'h0000_0000_0000_0201);
        run(1'b0, 1'b1, 6'd9, e, 0, 1'b0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/reveal_ctrl.md
Name: reveal_ctrl

Overview:
- Command sequencer in front of tile_state for the 8x8 minesweeper board.
- Accepts one player command at a time (flag or reveal) and converts it into single-cycle flag/reveal pulses on tile_state.
- Flood-fills zero-count regions through an internal 64-entry FIFO and detects loss (mine revealed) and win (all safe tiles revealed).

Parameters:
- NUM_MINES, 10, mines on board; legal range 1..63; win threshold is 64-NUM_MINES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- cmd_valid  in  1  player command present
- cmd_ready  out  1  controller accepts command this cycle
- cmd_flag  in  1  command is flag toggle
- cmd_reveal  in  1  command is reveal
- cmd_index  in  6  target tile, row=idx[5:3], col=idx[2:0]
- mines  in  64  mine map, bit i = tile i holds a mine; stable during a game
- flagged  in  64  from tile_state
- revealed  in  64  from tile_state
- reveal_count  in  6  from tile_state
- ts_index  out  6  tile index to tile_state
- ts_flag  out  1  one-cycle flag toggle pulse
- ts_reveal  out  1  one-cycle reveal pulse
- game_lost  out  1  sticky, mine revealed
- game_won  out  1  sticky, all safe tiles revealed

Behaviour:
- Reset: state IDLE; cmd_ready=0 during reset, then 1 in IDLE; ts_index=0; ts_flag=0; ts_reveal=0; game_lost=0; game_won=0; FIFO empty; queued bitmap=0.
- adj(i): combinational count (0..8) of mines among the 8 grid neighbours of i; off-grid neighbours are excluded, with no wrap across rows or columns.
- Handshake: a command is accepted when cmd_valid && cmd_ready. cmd_ready=1 only in IDLE and only while game_lost=0 and game_won=0. After game end, commands are never accepted.
- States: IDLE, FLAG, POP, EXPAND, CHECK, LOST, WON.
- IDLE, accept with cmd_reveal=1 (takes priority over cmd_flag when both are set):
  - flagged or revealed tile: no-op, stay IDLE.
  - mine tile: ts_reveal pulse for that index next cycle, then LOST.
  - otherwise: enqueue index, set queued[idx], go POP.
- IDLE, accept with cmd_flag=1 only: if !revealed[idx], go FLAG; otherwise no-op.
- FLAG: ts_flag=1, ts_index=idx for exactly one cycle, then IDLE.
- POP: dequeue head into cur; ts_reveal=1, ts_index=cur for one cycle. If adj(cur)==0, go EXPAND with dir=0. Otherwise go POP if FIFO is non-empty, else CHECK.
- EXPAND: one neighbour per cycle, dir order N,NE,E,SE,S,SW,W,NW.
  - Enqueue the neighbour and set its queued bit if it is on-grid && !revealed && !flagged && !queued.
  - After dir=7 (8 cycles total), go POP if FIFO is non-empty, else CHECK.
- queued prevents duplicates. Each tile is enqueued at most once per command, so depth 64 never overflows. Overflow is unreachable; the FIFO asserts nothing.
- CHECK: one cycle after the last reveal pulse, so reveal_count is updated. If reveal_count == 64-NUM_MINES, go WON; else IDLE. queued is cleared on CHECK exit.
- LOST: game_lost=1, held. WON: game_won=1, held. Both states are exited only by rst.
- ts_flag and ts_reveal are never high in the same cycle. ts_index holds its last value when no pulse is active.
- Latency:
  - flag: pulse 1 cycle after accept.
  - single non-zero reveal: pulse 1 cycle after accept, back in IDLE 3 cycles after accept.
  - flood: roughly 1 + 9 per zero tile + 1 per numbered tile + 1.
- Reset mid-flood: everything returns to reset values immediately. tile_state is reset from the same rst.

Optional Feature:
- Macro: REVEAL_CTRL_CHORD_EN.
- Defined: a reveal command on a revealed tile t, with adj(t)>0 and flagged-neighbour count == adj(t), loads every on-grid neighbour that is !revealed && !flagged into the FIFO via an 8-cycle EXPAND-like scan (CHORD state), then enters POP. A mine among them leads to LOST when popped: ts_reveal pulse, then LOST, remaining FIFO discarded. Zero-count neighbours flood normally.
- Undefined: a reveal on a revealed tile is a no-op; CHORD state and flagged-neighbour counter are not built.

Test Plan:
- Reset release, then cmd_flag idx=9 -> ts_flag=1, ts_index=9 for exactly one cycle; second flag on idx=9 -> second pulse; cmd_reveal idx=9 while flagged -> no pulse.
- mines bit 0 only, NUM_MINES=1, reveal idx=63 -> 63 reveal pulses covering every tile except 0, no duplicate indices, game_won=1, cmd_ready stays 0.
- mines bit 27, reveal idx=27 -> single ts_reveal idx=27, game_lost=1, later cmd_valid ignored (no pulses).
- mines bits 0,1,8, reveal idx=9 (adj=3) -> exactly one pulse for idx=9, back to IDLE, game_won=0.
- rst asserted mid-flood (after 10 pulses) -> all outputs 0 same cycle; after release, cmd_ready=1 and FIFO empty (next reveal of a numbered tile gives one pulse).
- With REVEAL_CTRL_CHORD_EN: mine 0 flagged, reveal revealed tile 9 (adj=1) -> pulses for unrevealed unflagged neighbours of 9 only, never idx 0.
